// File: rtl/instruction_cache.sv
`default_nettype none
// ============================================================================
// instruction_cache
//   Direct-mapped read-only instruction cache with 16-byte blocks, a
//   single-cycle flush and a saturating miss counter.
//   Revision: 1.0
// ============================================================================
module instruction_cache #(
  parameter int INDEX_BITS = 3
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  address,
  input  logic         read,
  input  logic         flush,
  output logic [31:0]  instruction,
  output logic         busywait,
  output logic         mem_read,
  output logic [27:0]  mem_address,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait,
  output logic [15:0]  miss_count
);

  localparam int TAG_BITS = 28 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_READ = 2'd1,
    S_UPDATE   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [LINES-1:0]      r_valid;
  logic [TAG_BITS-1:0]   r_tag [LINES];
  logic [127:0]          r_data [LINES];
  logic [127:0]          r_fill_buf;
  logic                  r_flush_pending;
  logic [15:0]           r_miss_count;

  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic [1:0]            w_word;
  logic                  w_hit;
  logic                  w_miss;
  logic                  w_drop_fill;
  logic                  w_unused_addr_bits;

  assign w_index            = address[3+INDEX_BITS:4];
  assign w_tag              = address[31:4+INDEX_BITS];
  assign w_word             = address[3:2];
  assign w_unused_addr_bits = ^address[1:0];

  assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_miss      = read && !w_hit;
  assign instruction = r_data[w_index][{w_word, 5'b0} +: 32];
  assign miss_count  = r_miss_count;
  // A flush arriving at any point of a fill (including the UPDATE cycle) voids it
  assign w_drop_fill = r_flush_pending || flush;

  always_comb begin
    w_next_state = r_state;
    busywait     = 1'b0;
    mem_read     = 1'b0;
    mem_address  = '0;
    case (r_state)
      S_IDLE: begin
        busywait = w_miss;
        if (w_miss) w_next_state = S_MEM_READ;
      end
      S_MEM_READ: begin
        busywait    = 1'b1;
        mem_read    = 1'b1;
        mem_address = {w_tag, w_index};
        if (!mem_busywait) w_next_state = S_UPDATE;
      end
      S_UPDATE: begin
        busywait     = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state         <= S_IDLE;
      r_valid         <= '0;
      r_flush_pending <= 1'b0;
      r_miss_count    <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (flush) r_valid <= '0;
          if (w_miss && (r_miss_count != 16'hFFFF)) r_miss_count <= r_miss_count + 16'd1;
        end
        S_MEM_READ: begin
          if (flush) r_flush_pending <= 1'b1;
        end
        S_UPDATE: begin
          if (w_drop_fill) r_valid <= '0;
          else             r_valid[w_index] <= 1'b1;
          r_flush_pending <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Block data is only valid in the cycle memory releases busywait, so it is
  // buffered there and committed to the array on the UPDATE edge.
  always_ff @(posedge CLK) begin
    if (r_state == S_MEM_READ && !mem_busywait) r_fill_buf <= mem_readdata;
    if (r_state == S_UPDATE && !w_drop_fill) begin
      r_data[w_index] <= r_fill_buf;
      r_tag[w_index]  <= w_tag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_cache.sv
`default_nettype none
// ============================================================================
// tb_instruction_cache
//   Directed and randomized fetch sequences against a line-level cache model.
//   Revision: 1.0
// ============================================================================
module tb_instruction_cache;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  address;
  logic         read;
  logic         flush;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata = '0;
  logic         mem_busywait = 1'b1;
  logic [15:0]  miss_count;

  int tests = 0;
  int fails = 0;

  // memory responder state
  int          mem_lat = 0;
  int          mem_cnt = 0;
  int          fills   = 0;
  logic [27:0] last_blk = '0;

  // reference model
  logic        m_valid [8];
  logic [24:0] m_tag   [8];
  int          m_miss;

  instruction_cache #(.INDEX_BITS(3)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .address      (address),
    .read         (read),
    .flush        (flush),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait),
    .miss_count   (miss_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [27:0] blk, input logic [1:0] n);
    return {blk, n, 2'b00} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [127:0] block_data(input logic [27:0] blk);
    return {mem_word(blk, 2'd3), mem_word(blk, 2'd2), mem_word(blk, 2'd1), mem_word(blk, 2'd0)};
  endfunction

  // Memory drops busywait in the (mem_lat+1)-th cycle of a request.
  always @(negedge CLK) begin
    if (mem_read) begin
      if (mem_cnt == mem_lat) begin
        mem_busywait <= 1'b0;
        mem_readdata <= block_data(mem_address);
        last_blk     <= mem_address;
        fills        <= fills + 1;
        mem_cnt      <= 0;
      end else begin
        mem_busywait <= 1'b1;
        mem_readdata <= {$urandom, $urandom, $urandom, $urandom};
        mem_cnt      <= mem_cnt + 1;
      end
    end else begin
      mem_busywait <= 1'b1;
      mem_readdata <= {$urandom, $urandom, $urandom, $urandom};
      mem_cnt      <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_fill(input logic [31:0] a);
    m_valid[a[6:4]] = 1'b1;
    m_tag[a[6:4]]   = a[31:7];
  endtask

  task automatic model_count_miss();
    if (m_miss < 65535) m_miss++;
  endtask

  // One fetch: hit expected per model, else a fill of lat+3 busy cycles.
  task automatic fetch(input logic [31:0] a, input int lat);
    logic exp_hit;
    int   nb;
    int   f0;
    exp_hit = m_valid[a[6:4]] && (m_tag[a[6:4]] == a[31:7]);
    f0      = fills;
    @(posedge CLK); #1;
    mem_lat = lat;
    address = a;
    read    = 1'b1;
    @(negedge CLK);
    check("busy_cycle0", busywait, !exp_hit);
    nb = 0;
    while (busywait === 1'b1 && nb < 200) begin
      nb++;
      @(negedge CLK);
    end
    if (!exp_hit) begin
      model_fill(a);
      model_count_miss();
    end
    check("busy_cycles", nb, exp_hit ? 0 : lat + 3);
    check("busy_released", busywait, 1'b0);
    check("instruction", instruction, mem_word(a[31:4], a[3:2]));
    check("miss_count", miss_count, m_miss);
    check("fills", fills - f0, exp_hit ? 0 : 1);
    if (!exp_hit) check("mem_address", last_blk, a[31:4]);
    @(posedge CLK); #1;
    read = 1'b0;
  endtask

  initial begin
    int f0;
    int nb;
    RESET   = 1'b1;
    address = '0;
    read    = 1'b0;
    flush   = 1'b0;
    m_miss  = 0;
    model_clear();
    #2;
    check("rst_busywait_idle", busywait, 1'b0);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_address", mem_address, 28'd0);
    check("rst_miss_count", miss_count, 16'd0);
    read = 1'b1; #1;
    check("rst_busywait_read", busywait, 1'b1);
    read = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;

    // cold miss with latency 5, then same-block hits
    fetch(32'h0000_0000, 5);
    fetch(32'h0000_0040, 2);
    fetch(32'h0000_0044, 0);
    fetch(32'h0000_0048, 0);
    fetch(32'h0000_004C, 0);

    // conflict on index 0
    fetch(32'h0000_0000, 1);
    fetch(32'h0000_0080, 0);
    fetch(32'h0000_0000, 3);

    // flush in IDLE: same-cycle read served from old contents
    @(posedge CLK); #1;
    address = 32'h0000_0004;
    read    = 1'b1;
    flush   = 1'b1;
    @(negedge CLK);
    check("flush_cycle_busy", busywait, 1'b0);
    check("flush_cycle_instr", instruction, mem_word(28'd0, 2'd1));
    @(posedge CLK); #1;
    flush = 1'b0;
    read  = 1'b0;
    model_clear();
    fetch(32'h0000_0004, 1);
    fetch(32'h0000_0040, 0);

    // flush during MEM_READ: fill voided, CPU re-misses
    f0 = fills;
    @(posedge CLK); #1;
    mem_lat = 3;
    address = 32'h0000_0108;
    read    = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;
    nb = 0;
    @(negedge CLK);
    while (busywait === 1'b1 && nb < 200) begin
      nb++;
      @(negedge CLK);
    end
    model_clear();
    model_count_miss();
    model_count_miss();
    model_fill(32'h0000_0108);
    check("fmr_busy_released", busywait, 1'b0);
    check("fmr_fills", fills - f0, 2);
    check("fmr_miss_count", miss_count, m_miss);
    check("fmr_instruction", instruction, mem_word(28'h10, 2'd2));
    @(posedge CLK); #1;
    read = 1'b0;
    fetch(32'h0000_0040, 0);

    // reset two cycles into MEM_READ
    @(posedge CLK); #1;
    mem_lat = 10;
    address = 32'h0000_0200;
    read    = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("pre_rst_mem_read", mem_read, 1'b1);
    RESET = 1'b1;
    #1;
    check("mid_rst_mem_read", mem_read, 1'b0);
    check("mid_rst_busywait", busywait, 1'b1);
    check("mid_rst_miss_count", miss_count, 16'd0);
    @(negedge CLK);
    RESET = 1'b0;
    read  = 1'b0;
    model_clear();
    m_miss = 0;
    fetch(32'h0000_0200, 1);
    fetch(32'h0000_0040, 0);

    // randomized fetches with occasional idle flushes
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge CLK); #1;
        flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        model_clear();
      end else begin
        fetch(32'($urandom_range(0, 255)) << 2, $urandom_range(0, 4));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_cache.md
# instruction_cache

Direct-mapped, read-only instruction cache between the `cpu` fetch stage and the block-wide instruction memory. It returns 32-bit instructions on hit in the same cycle and stalls fetch via `busywait` on miss while it fills a 128-bit block. It provides a single-cycle `flush` used by the OS-initiated context-switch path, and a saturating miss counter for the performance-loss measurements.

## Interface
- `INDEX_BITS`, default 3: line index width; 2^INDEX_BITS lines, 16-byte (4-word) blocks.
- `TAG_BITS`, fixed at 28−INDEX_BITS: tag width, address[31:4+INDEX_BITS].
- `CLK` input 1: single clock, rising edge.
- `RESET` input 1: asynchronous, active-high reset.
- `address` input 32: fetch byte address; bits[1:0] ignored.
- `read` input 1: fetch request, held by the CPU until `busywait` is low.
- `flush` input 1: one-cycle pulse; invalidates every line.
- `instruction` output 32: selected word; valid when `read`=1 and `busywait`=0.
- `busywait` output 1: CPU stall.
- `mem_read` output 1: block read request to memory.
- `mem_address` output 28: block address {tag, index}.
- `mem_readdata` input 128: block data; word n = bits[32n+31:32n].
- `mem_busywait` input 1: high while memory is busy. It drops for one cycle with `mem_readdata` valid.
- `miss_count` output 16: saturating count of fills started.

## Operation
- Storage per line: valid bit, tag, 128-bit data.
- Address fields: index = address[3+INDEX_BITS:4]; word = address[3:2].
- `hit` = valid[index] && tag[index] == address tag. `hit` and `instruction` are combinational.
- FSM states:
  - IDLE: `busywait` = `read && !hit`. On a miss, go to MEM_READ at the next edge and increment `miss_count` unless it is 0xFFFF.
  - MEM_READ: `mem_read`=1, `mem_address` = {tag, index} of the held `address`, `busywait`=1. On an edge with `mem_busywait`=0, go to UPDATE.
  - UPDATE: `mem_read`=0, `busywait`=1. At the edge, write data and tag, set valid (subject to flush below), then go to IDLE.
- Flush:
  - In IDLE, all valid bits clear at the next edge. A read presented in the same cycle is served from pre-flush contents.
  - In MEM_READ or UPDATE, set `flush_pending`. At the UPDATE edge, clear all valid bits, do not set the filled line valid, and clear `flush_pending`. The CPU then re-misses.
- `read`=0 in IDLE: `busywait`=0 and the FSM stays in IDLE.
- `mem_address` and `mem_read` are 0 outside MEM_READ.

## Timing
- Reset (async, immediate):
  - state = IDLE; all valid = 0; `flush_pending` = 0; `miss_count` = 0; `mem_read` = 0.
  - `busywait` = `read` (every access misses); `instruction` = don't-care.
- Reset mid-fill aborts the fill and deasserts `mem_read` immediately. No line is written.
- Hit latency: 0 cycles.
- Miss: `busywait` rises combinationally in cycle 0 and `mem_read` rises after edge 1. If memory drops `mem_busywait` in cycle 1+L, UPDATE runs in the next cycle. The hit is served in cycle L+3 after the miss. L = memory latency ≥ 0.
- `mem_busywait` sampled low on the first MEM_READ edge (L=0) is legal.
- The cache does not register `address`. The CPU holds `address` stable while `busywait`=1.

## Test plan
- Reset then `read` at 0x00000000 with memory latency 5 → `busywait`=1 for 8 cycles, one `mem_read` with `mem_address`=0, then `instruction` = word0 of the block and `miss_count`=1.
- Fill block 0x40 and read 0x44, 0x48, 0x4C → all hits, `busywait`=0, correct words, `miss_count` unchanged.
- Conflict: with INDEX_BITS=3, read 0x000 then 0x080 then 0x000 → three misses, `miss_count`=3, correct data each time.
- Flush pulse in IDLE after filling 0x000 → next read of 0x000 misses. A read in the flush cycle itself hits with the old data.
- Flush pulse during MEM_READ → fill completes, line not valid, immediate re-miss with a second `mem_read`.
- `RESET` asserted 2 cycles into MEM_READ → `mem_read` drops within the same time step, all lines invalid, `miss_count`=0. A subsequent read refills correctly.
